// File: rtl/depth_pkg.sv
// depth_pkg: shared state encoding, result record and escape threshold for depth_engine.
package depth_pkg;
    localparam int THRESH_W = 257;
    localparam int RES_DEPTH_W = 32;
    localparam int RES_TAG_W = 64;

    typedef enum logic [2:0] {IDLE, SQUARE, SCALE, UPDATE, DONE} state_t;

    typedef struct packed {
        logic [RES_DEPTH_W-1:0] depth;
        logic                   escaped;
        logic [RES_TAG_W-1:0]   tag;
    } result_t;

    // 4.0 expressed with 2*frac fraction bits (the raw product domain), clipped to 2*width+1 bits
    function automatic logic [THRESH_W-1:0] thresh(input int frac, input int width);
        return (THRESH_W'(1) << (2 * frac + 2)) & ((THRESH_W'(1) << (2 * width + 1)) - THRESH_W'(1));
    endfunction
endpackage

// File: rtl/depth_engine_cplx_square.sv
// cplx_square: registered complex square of z in two stages (full products, then rescale plus escape test).
module cplx_square
    import depth_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FRAC  = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sq_en,
    input  logic             sc_en,
    input  logic [WIDTH-1:0] re,
    input  logic [WIDTH-1:0] im,
    output logic [WIDTH-1:0] rr_s,
    output logic [WIDTH-1:0] ii_s,
    output logic [WIDTH-1:0] ri2_s,
    output logic             esc
);
    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW:0] TH = (PW + 1)'(thresh(FRAC, WIDTH));

    logic signed [PW-1:0] re_x, im_x, rr, ii, ri;
    logic signed [PW:0] ri2, mag;

    assign re_x = PW'($signed(re));
    assign im_x = PW'($signed(im));
    // one extra bit keeps both 2*ri and rr+ii free of overflow
    assign ri2 = {ri, 1'b0};
    assign mag = (PW + 1)'(rr) + (PW + 1)'(ii);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr    <= '0;
            ii    <= '0;
            ri    <= '0;
            rr_s  <= '0;
            ii_s  <= '0;
            ri2_s <= '0;
            esc   <= 1'b0;
        end else begin
            if (sq_en) begin
                rr <= re_x * re_x;
                ii <= im_x * im_x;
                ri <= re_x * im_x;
            end
            if (sc_en) begin
                rr_s  <= WIDTH'(rr >>> FRAC);
                ii_s  <= WIDTH'(ii >>> FRAC);
                ri2_s <= WIDTH'(ri2 >>> FRAC);
                esc   <= mag > TH;
            end
        end
    end
endmodule

// File: rtl/depth_engine.sv
// depth_engine: escape depth of one Mandelbrot/Julia point per transaction, valid/ready on both sides.
module depth_engine
    import depth_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int FRAC   = 60,
    parameter int ITER_W = 10,
    parameter int TAG_W  = 20
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_re,
    input  logic [WIDTH-1:0]  in_im,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              julia_en,
    input  logic [WIDTH-1:0]  julia_re,
    input  logic [WIDTH-1:0]  julia_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_depth,
    output logic              out_escaped,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);
    if (WIDTH - FRAC < 4) begin : g_bad_frac
        $error("depth_engine: WIDTH-FRAC must be at least 4");
    end
    if (ITER_W > RES_DEPTH_W || TAG_W > RES_TAG_W || 2 * WIDTH + 1 > THRESH_W) begin : g_bad_width
        $error("depth_engine: parameter exceeds result/threshold field width");
    end

    state_t            state;
    logic [ITER_W-1:0] n, limit;
    logic [TAG_W-1:0]  tag;
    logic [WIDTH-1:0]  z_re, z_im, c_re, c_im, rr_s, ii_s, ri2_s;
    logic              esc;
    result_t           res;

    assign in_ready    = state == IDLE;
    assign busy        = state != IDLE;
    assign out_depth   = ITER_W'(res.depth);
    assign out_escaped = res.escaped;
    assign out_tag     = TAG_W'(res.tag);

    cplx_square #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sq (
        .clk  (sysclk),
        .rst_n(reset_n),
        .sq_en(state == SQUARE),
        .sc_en(state == SCALE),
        .re   (z_re),
        .im   (z_im),
        .rr_s (rr_s),
        .ii_s (ii_s),
        .ri2_s(ri2_s),
        .esc  (esc)
    );

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            n         <= '0;
            limit     <= '0;
            tag       <= '0;
            z_re      <= '0;
            z_im      <= '0;
            c_re      <= '0;
            c_im      <= '0;
            res       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    limit <= max_iter;
                    tag   <= in_tag;
                    c_re  <= julia_en ? julia_re : in_re;
                    c_im  <= julia_en ? julia_im : in_im;
                    z_re  <= julia_en ? in_re : '0;
                    z_im  <= julia_en ? in_im : '0;
                    n     <= '0;
                    state <= SQUARE;
                end
                SQUARE: state <= SCALE;
                SCALE:  state <= UPDATE;
                UPDATE: if (esc || n == limit) begin
                    res   <= '{depth: RES_DEPTH_W'(esc ? n : limit), escaped: esc, tag: RES_TAG_W'(tag)};
                    state <= DONE;
                end else begin
                    z_re  <= rr_s - ii_s + c_re;
                    z_im  <= ri2_s + c_im;
                    n     <= n + ITER_W'(1);
                    state <= SQUARE;
                end
                // out_valid rises one cycle after entering DONE
                DONE: if (!out_valid) begin
                    out_valid <= 1'b1;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_depth_engine.sv
// tb_depth_engine: directed vectors into a result scoreboard, popped by a handshake monitor.
module tb_depth_engine;
    localparam int W = 64, IW = 10, TW = 20;

    typedef struct packed {
        logic [IW-1:0] depth;
        logic          escaped;
        logic [TW-1:0] tag;
    } exp_t;

    logic          sysclk = 1'b0, reset_n = 1'b1, in_valid = 1'b0, julia_en = 1'b0, out_ready = 1'b1;
    logic [W-1:0]  in_re = '0, in_im = '0, julia_re = '0, julia_im = '0;
    logic [TW-1:0] in_tag = '0;
    logic [IW-1:0] max_iter = '0;
    logic          in_ready, out_valid, out_escaped, busy;
    logic [IW-1:0] out_depth;
    logic [TW-1:0] out_tag;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, acc_cyc = 0, rise_cyc = 0;
    logic ov_q = 1'b0;

    depth_engine dut (
        .sysclk(sysclk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_tag(in_tag), .max_iter(max_iter),
        .julia_en(julia_en), .julia_re(julia_re), .julia_im(julia_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_depth(out_depth),
        .out_escaped(out_escaped), .out_tag(out_tag), .busy(busy)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    function automatic logic [W-1:0] hx(input int h);
        return W'(longint'(h) <<< 59);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    always @(negedge sysclk) begin
        exp_t e;
        if (out_valid && !ov_q) rise_cyc = cyc;
        ov_q = out_valid;
        if (reset_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got tag %0d, required no result", out_tag);
            end else begin
                e = q.pop_front();
                chk($sformatf("depth[tag %0d]", e.tag), 64'(out_depth), 64'(e.depth));
                chk($sformatf("escaped[tag %0d]", e.tag), 64'(out_escaped), 64'(e.escaped));
                chk($sformatf("tag[tag %0d]", e.tag), 64'(out_tag), 64'(e.tag));
            end
        end
    end

    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic [TW-1:0] tag,
                        input logic [IW-1:0] mi, input logic jen, input logic [W-1:0] jre,
                        input logic [W-1:0] jim, input logic push, input logic [IW-1:0] d, input logic e);
        int t = 0;
        @(negedge sysclk);
        in_re = re; in_im = im; in_tag = tag; max_iter = mi;
        julia_en = jen; julia_re = jre; julia_im = jim; in_valid = 1'b1;
        while (!in_ready && t < 2000) begin
            @(negedge sysclk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout[tag %0d]: in_ready %b, required 1", tag, in_ready);
            in_valid = 1'b0;
            return;
        end
        if (push) q.push_back('{d, e, tag});
        @(posedge sysclk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic mand(input logic [W-1:0] cr, input logic [W-1:0] ci, input logic [TW-1:0] tag,
                        input logic [IW-1:0] mi, input logic push, input logic [IW-1:0] d, input logic e);
        send(cr, ci, tag, mi, 1'b0, '0, '0, push, d, e);
    endtask

    task automatic jul(input logic [W-1:0] zr, input logic [W-1:0] zi, input logic [TW-1:0] tag,
                       input logic [IW-1:0] mi, input logic [IW-1:0] d, input logic e);
        send(zr, zi, tag, mi, 1'b1, '0, '0, 1'b1, d, e);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 3000) begin
            @(negedge sysclk);
            t++;
        end
        checks++;
        if (q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_%s: %0d results outstanding, out_valid %b, required 0 and 0", name, q.size(), out_valid);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_depth"}, 64'(out_depth), 64'd0);
        chk({name, "_escaped"}, 64'(out_escaped), 64'd0);
        chk({name, "_tag"}, 64'(out_tag), 64'd0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1 chk_reset("reset");
        repeat (2) @(negedge sysclk);
        reset_n = 1'b1;

        // c=0 never escapes: 201 evaluations, valid 3*201+1 edges after accept
        mand('0, '0, 1, 200, 1'b1, 200, 1'b0);
        drain("c0");
        chk("latency_c0", 64'(rise_cyc - acc_cyc), 64'd604);

        mand(hx(6), '0, 2, 100, 1'b1, 1, 1'b1);
        drain("c3");
        chk("latency_c3", 64'(rise_cyc - acc_cyc), 64'd7);

        mand(hx(4), '0, 3, 100, 1'b1, 2, 1'b1);
        mand(hx(2), hx(2), 4, 100, 1'b1, 2, 1'b1);
        mand(hx(-4), '0, 5, 50, 1'b1, 50, 1'b0);
        drain("mandel");

        jul(hx(1), '0, 10, 30, 30, 1'b0);
        jul(hx(5), '0, 11, 30, 0, 1'b1);
        jul('0, '0, 12, 0, 0, 1'b0);
        jul(hx(5), '0, 13, 0, 0, 1'b1);
        mand('0, '0, 14, 0, 1'b1, 0, 1'b0);
        drain("julia");

        mand(hx(6), '0, 7, 100, 1'b1, 1, 1'b1);
        mand(hx(4), '0, 8, 100, 1'b1, 2, 1'b1);
        drain("b2b");
        chk("hold_tag", 64'(out_tag), 64'd8);
        chk("hold_depth", 64'(out_depth), 64'd2);
        chk("hold_escaped", 64'(out_escaped), 64'd1);

        out_ready = 1'b0;
        mand(hx(6), '0, 21, 100, 1'b1, 1, 1'b1);
        for (int t = 0; t < 100 && !out_valid; t++) @(negedge sysclk);
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        repeat (20) begin
            @(negedge sysclk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_depth", 64'(out_depth), 64'd1);
            chk("bp_tag", 64'(out_tag), 64'd21);
        end
        @(posedge sysclk);
        #1 out_ready = 1'b1;
        @(posedge sysclk);
        #1;
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_out_valid_after", 64'(out_valid), 64'd0);
        drain("bp");

        // configuration changed after accept must not affect the point in flight
        mand(hx(4), '0, 30, 100, 1'b1, 2, 1'b1);
        max_iter = 0; julia_en = 1'b1; julia_re = hx(6); julia_im = hx(6);
        drain("late_cfg");

        mand('0, '0, 99, 200, 1'b0, 0, 1'b0);
        repeat (10) @(negedge sysclk);
        max_iter = 0; julia_en = 1'b1; julia_re = hx(6);
        #2 reset_n = 1'b0;
        #1 chk_reset("abort");
        repeat (2) @(negedge sysclk);
        chk_reset("abort_hold");
        reset_n = 1'b1;
        mand(hx(2), hx(2), 40, 100, 1'b1, 2, 1'b1);
        drain("post_reset");
        chk("latency_post_reset", 64'(rise_cyc - acc_cyc), 64'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/depth_engine.md
Name: depth_engine

Overview:
- Parametrised successor to the single-pixel Mandelbrot iterator: computes the escape depth of one point per transaction.
- Fixed-point width, fraction bits, iteration-counter width and a pass-through tag width are all parameters.
- max_iter is a runtime input instead of a constant; Julia mode is supported alongside Mandelbrot.
- Sits between the pixel-coordinate generator (upstream, valid/ready) and the colour mapper (downstream, valid/ready with backpressure).

Parameters:
- WIDTH, 64, signed fixed-point word length of z and c.
- FRAC, 60, fraction bits. Elaboration-time assertion: WIDTH-FRAC >= 4.
- ITER_W, 10, width of max_iter and depth.
- TAG_W, 20, width of the opaque tag carried from input to output (pixel index).

Ports:
- sysclk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a point is offered.
- in_ready  out  1  engine can accept a point.
- in_re, in_im  in  WIDTH  signed point: c in Mandelbrot mode, z0 in Julia mode.
- in_tag  in  TAG_W  tag returned with the result.
- max_iter  in  ITER_W  iteration limit, sampled at accept.
- julia_en  in  1  0 = Mandelbrot, 1 = Julia; sampled at accept.
- julia_re, julia_im  in  WIDTH  Julia constant c; sampled at accept.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_depth  out  ITER_W  escape depth.
- out_escaped  out  1  1 = escaped, 0 = hit max_iter.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, SQUARE, SCALE, UPDATE, DONE.
- Reset (async, reset_n=0): state=IDLE, in_ready=1, out_valid=0, out_depth=0, out_escaped=0, out_tag=0, busy=0, z=0, n=0.
- IDLE:
  - in_ready=1.
  - Accept when in_valid & in_ready; latch max_iter, julia_en, tag and c.
  - Mandelbrot: z0=0, c=in. Julia: z0=in, c=julia_*.
  - Set n=0 and go to SQUARE.
- in_ready=0 in every state other than IDLE; one point in flight.
- SQUARE: register full-precision 2*WIDTH products rr=re*re, ii=im*im, ri=re*im.
- SCALE:
  - Register rr>>>FRAC, ii>>>FRAC and (2*ri)>>>FRAC, truncated to WIDTH.
  - Register esc = (rr+ii) > (4 << 2*FRAC), computed in 2*WIDTH+1 bits with no overflow.
  - "> 4" is strict: |z|^2 == 4 is not escaped.
- UPDATE, in priority order:
  - if esc: depth=n, escaped=1, go to DONE;
  - else if n == max_iter: depth=max_iter, escaped=0, go to DONE;
  - else z = (rr_s - ii_s + c_re, 2ri_s + c_im), wrapped to WIDTH; n++; go to SQUARE.
- Each iteration costs 3 cycles.
  - k = d+1 when escaped at depth d; k = max_iter+1 otherwise.
  - out_valid first rises on rising edge 3k+1 after the accept edge.
- DONE:
  - out_valid=1; out_depth, out_escaped and out_tag are stable until handshake.
  - On out_valid & out_ready: out_valid=0 and go to IDLE. in_ready=1 on the following cycle.
  - The outputs keep their last values after handshake.
- Stalled out_ready holds DONE indefinitely with outputs unchanged.
- Changes to max_iter, julia_en or julia_* after accept are ignored until the next accept.
- max_iter=0: one evaluation of z0, then depth=0. escaped=1 only if |z0|^2 > 4 (Julia).
- reset_n low mid-iteration aborts the point immediately; no result is emitted.

Decomposition:
- Package depth_pkg holds:
  - the state enum;
  - the escape-threshold function thresh(FRAC, WIDTH);
  - the result struct {depth, escaped, tag}.
- Sub-module cplx_square (WIDTH, FRAC) holds the SQUARE and SCALE registers and the esc compare. Instantiated once.
- The FSM, counter and handshakes live in depth_engine.

Test Plan:
- Mandelbrot, c=0, max_iter=200 -> depth=200, escaped=0; out_valid on edge 3*201+1=604 after accept.
- Mandelbrot, c=3.0 -> depth=1, escaped=1. c=2.0 -> depth=2, escaped=1 (|z1|^2=4 not escaped). c=1+1i -> depth=2, escaped=1.
- Mandelbrot, c=-2.0, max_iter=50 -> z sticks at 2, |z|^2=4 never strictly exceeds -> depth=50, escaped=0.
- Julia, julia_c=0: in=0.5 -> depth=max_iter, escaped=0; in=2.5 -> depth=0, escaped=1. max_iter=0 with in=0 -> depth=0, escaped=0.
- Backpressure: out_ready=0 for 20 cycles -> out_valid and result stable, in_ready=0 throughout; out_ready=1 -> handshake, in_ready=1 next cycle. Back-to-back tags 7, 8 return in order.
- Drop reset_n mid-iteration, with max_iter or julia_c also changed after accept -> all outputs return to reset values asynchronously. The next point completes correctly using the values sampled at its own accept.
